// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Pure declarations, no logic; no latency.
// No flow control; imported by the interface, counter and top.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Bits needed to hold an index 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial-side signals of the serializer.
// Wires only, no latency.
// Producer sees in_ready; consumer throttles with ser_en.
interface piso_serializer_if #(
  parameter int WIDTH = 16
) ();
  import piso_pkg::*;

  logic [WIDTH-1:0]            data_in;
  logic                        in_valid;
  logic                        in_ready;
  logic                        ser_en;
  logic                        ser_out;
  logic                        ser_valid;
  logic [cnt_width(WIDTH)-1:0] bit_idx;
  logic                        done;

  // Serializer side.
  modport slave (
    input  data_in, in_valid, ser_en,
    output in_ready, ser_out, ser_valid, bit_idx, done
  );

  // Producer/consumer side.
  modport master (
    output data_in, in_valid, ser_en,
    input  in_ready, ser_out, ser_valid, bit_idx, done
  );

endinterface

// File: rtl/piso_serializer_counter.sv
// Modulo-N counter with enable, synchronous clear and a last-value flag.
// Count updates one cycle after en; last is decoded from the register.
// No backpressure; clear has priority over enable.
module mod_counter
  import piso_pkg::*;
#(
  parameter int N = 16,
  parameter int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last = (cnt_q == W'(N - 1));
  assign cnt  = cnt_q;

  // Next count: clear wins, otherwise advance and wrap after N-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with configurable width and bit order.
// First bit appears the cycle after the load handshake; one bit per ser_en cycle.
// in_ready only in IDLE or on the consumed last bit, which allows gapless streaming.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input logic              clk,
  input logic              rst,
  piso_serializer_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  piso_state_t      state_q;
  piso_state_t      state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic             done_q;
  logic             done_d;

  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             advance;
  logic             last_taken;
  logic             load;

  // A bit is consumed only while shifting with the consumer enabled.
  assign advance    = (state_q == SHIFT) && bus.ser_en;
  assign last_taken = advance && cnt_last;
  assign load       = bus.in_valid && bus.in_ready;

  // Bit position within the word; cleared on every load.
  mod_counter #(
    .N (WIDTH),
    .W (CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (advance),
    .clr  (load),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // Next state, shift register contents, ready and done decode.
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    done_d       = last_taken;
    bus.in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bus.in_ready = last_taken;
        if (last_taken && !bus.in_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load) begin
      sreg_d = bus.data_in;
    end else if (advance) begin
      sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  // State, data and done registers; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      done_q  <= done_d;
    end
  end

  // Serial outputs decoded from registers only.
  always_comb begin
    bus.ser_valid = (state_q == SHIFT);
    bus.ser_out   = IDLE_LEVEL;
    if (state_q == SHIFT) begin
      bus.ser_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    end
    bus.bit_idx = cnt;
    bus.done    = done_q;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench: three serializer configurations on one clock.
module tb_piso_serializer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  piso_serializer_if #(.WIDTH(16)) m_if ();
  piso_serializer_if #(.WIDTH(16)) l_if ();
  piso_serializer_if #(.WIDTH(4))  w_if ();

  piso_serializer #(.WIDTH(16), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk (clk), .rst (rst), .bus (m_if.slave)
  );
  piso_serializer #(.WIDTH(16), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk (clk), .rst (rst), .bus (l_if.slave)
  );
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_w (
    .clk (clk), .rst (rst), .bus (w_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset values while asserted and ready after release.
  task automatic test_reset();
    logic [7:0] got;
    #2;
    got = {m_if.ser_valid, m_if.ser_out, m_if.bit_idx, m_if.done, l_if.ser_valid};
    checks++;
    if (got !== 8'b0000_0000) begin
      errors++;
      $display("FAIL reset_m: got %b expected 00000000", got);
    end
    checks++;
    if ({w_if.ser_valid, w_if.ser_out, w_if.done} !== 3'b010) begin
      errors++;
      $display("FAIL reset_w: got %b expected 010", {w_if.ser_valid, w_if.ser_out, w_if.done});
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({m_if.in_ready, l_if.in_ready, w_if.in_ready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 111", {m_if.in_ready, l_if.in_ready, w_if.in_ready});
    end
  endtask

  // Single word, MSB first, ser_en held high.
  task automatic test_msb_first(input logic [15:0] word);
    logic [6:0] got;
    logic [6:0] exp;
    m_if.data_in  = word;
    m_if.in_valid = 1'b1;
    m_if.ser_en   = 1'b1;
    #1;
    checks++;
    if (m_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL msb_load_ready %h: got %b expected 1", word, m_if.in_ready);
    end
    step();
    m_if.in_valid = 1'b0;
    m_if.data_in  = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      got = {m_if.ser_valid, m_if.ser_out, m_if.bit_idx, m_if.done};
      exp = {1'b1, word[15-i], 4'(i), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL msb_bit %h[%0d]: got %b expected %b", word, i, got, exp);
      end
      step();
    end
    checks++;
    if ({m_if.done, m_if.ser_valid, m_if.ser_out, m_if.in_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL msb_done %h: got %b expected 1001", word,
               {m_if.done, m_if.ser_valid, m_if.ser_out, m_if.in_ready});
    end
    step();
    checks++;
    if (m_if.done !== 1'b0) begin
      errors++;
      $display("FAIL msb_done_pulse %h: got %b expected 0", word, m_if.done);
    end
  endtask

  // Single word, LSB first: 16'hF0F0 goes out as 0000 1111 0000 1111.
  task automatic test_lsb_first();
    logic [15:0] seq;
    logic [6:0]  got;
    logic [6:0]  exp;
    seq = 16'b0000_1111_0000_1111;
    l_if.data_in  = 16'hF0F0;
    l_if.in_valid = 1'b1;
    l_if.ser_en   = 1'b1;
    step();
    l_if.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      got = {l_if.ser_valid, l_if.ser_out, l_if.bit_idx, l_if.done};
      exp = {1'b1, seq[15-i], 4'(i), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL lsb_bit[%0d]: got %b expected %b", i, got, exp);
      end
      step();
    end
    checks++;
    if ({l_if.done, l_if.ser_valid} !== 2'b10) begin
      errors++;
      $display("FAIL lsb_done: got %b expected 10", {l_if.done, l_if.ser_valid});
    end
    l_if.ser_en = 1'b0;
  endtask

  // Stall on bit 3 for three cycles; done moves to T+20.
  task automatic test_stall();
    logic [15:0] word;
    int          idx;
    logic [7:0]  got;
    logic [7:0]  exp;
    word = 16'hCCCC;
    m_if.data_in  = word;
    m_if.in_valid = 1'b1;
    m_if.ser_en   = 1'b1;
    step();
    m_if.in_valid = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      m_if.ser_en = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      idx = (c <= 3) ? c - 1 : (c <= 7) ? 3 : c - 4;
      #1;
      got = {m_if.ser_valid, m_if.ser_out, m_if.bit_idx, m_if.done, m_if.in_ready};
      exp = {1'b1, word[15-idx], 4'(idx), 1'b0, (c == 19)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stall_cycle %0d: got %b expected %b", c, got, exp);
      end
      step();
    end
    checks++;
    if ({m_if.done, m_if.ser_valid} !== 2'b10) begin
      errors++;
      $display("FAIL stall_done: got %b expected 10", {m_if.done, m_if.ser_valid});
    end
  endtask

  // Two words with in_valid held: 32 contiguous bits, done at T+17 and T+33.
  task automatic test_back_to_back();
    logic [15:0] word;
    int          idx;
    logic [7:0]  got;
    logic [7:0]  exp;
    m_if.data_in  = 16'h8080;
    m_if.in_valid = 1'b1;
    m_if.ser_en   = 1'b1;
    step();
    m_if.data_in = 16'hE000;
    for (int c = 1; c <= 32; c++) begin
      if (c == 17) m_if.in_valid = 1'b0;
      #1;
      word = (c <= 16) ? 16'h8080 : 16'hE000;
      idx  = (c - 1) % 16;
      got  = {m_if.ser_valid, m_if.ser_out, m_if.bit_idx, m_if.done, m_if.in_ready};
      exp  = {1'b1, word[15-idx], 4'(idx), (c == 17), (c == 16 || c == 32)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_cycle %0d: got %b expected %b", c, got, exp);
      end
      step();
    end
    checks++;
    if ({m_if.done, m_if.ser_valid, m_if.ser_out} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_done2: got %b expected 100", {m_if.done, m_if.ser_valid, m_if.ser_out});
    end
  endtask

  // Reset at bit 7 aborts the word; no done afterwards.
  task automatic test_reset_mid();
    m_if.data_in  = 16'h1234;
    m_if.in_valid = 1'b1;
    m_if.ser_en   = 1'b1;
    step();
    m_if.in_valid = 1'b0;
    for (int c = 1; c < 8; c++) step();
    checks++;
    if (m_if.bit_idx !== 4'd7) begin
      errors++;
      $display("FAIL rmid_idx: got %0d expected 7", m_if.bit_idx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m_if.ser_valid, m_if.ser_out, m_if.done, m_if.bit_idx} !== 7'b0) begin
      errors++;
      $display("FAIL rmid_abort: got %b expected 0000000",
               {m_if.ser_valid, m_if.ser_out, m_if.done, m_if.bit_idx});
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (m_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_ready: got %b expected 1", m_if.in_ready);
    end
    m_if.ser_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if ({m_if.done, m_if.ser_valid} !== 2'b00) begin
        errors++;
        $display("FAIL rmid_quiet %0d: got %b expected 00", c, {m_if.done, m_if.ser_valid});
      end
    end
  endtask

  // WIDTH=4, idle level 1: 4'h5 goes out as 0,1,0,1 with done at T+5.
  task automatic test_width4();
    logic [3:0] seq;
    logic [4:0] got;
    logic [4:0] exp;
    seq = 4'b0101;
    checks++;
    if ({w_if.ser_out, w_if.ser_valid} !== 2'b10) begin
      errors++;
      $display("FAIL w4_idle: got %b expected 10", {w_if.ser_out, w_if.ser_valid});
    end
    w_if.data_in  = 4'h5;
    w_if.in_valid = 1'b1;
    w_if.ser_en   = 1'b1;
    step();
    w_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got = {w_if.ser_valid, w_if.ser_out, w_if.bit_idx, w_if.done};
      exp = {1'b1, seq[3-i], 2'(i), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL w4_bit[%0d]: got %b expected %b", i, got, exp);
      end
      step();
    end
    checks++;
    if ({w_if.done, w_if.ser_valid, w_if.ser_out} !== 3'b101) begin
      errors++;
      $display("FAIL w4_done: got %b expected 101", {w_if.done, w_if.ser_valid, w_if.ser_out});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    m_if.data_in = '0; m_if.in_valid = 1'b0; m_if.ser_en = 1'b0;
    l_if.data_in = '0; l_if.in_valid = 1'b0; l_if.ser_en = 1'b0;
    w_if.data_in = '0; w_if.in_valid = 1'b0; w_if.ser_en = 1'b0;
    test_reset();
    test_msb_first(16'hAAAA);
    test_lsb_first();
    step();
    test_stall();
    step();
    test_back_to_back();
    step();
    test_reset_mid();
    test_msb_first(16'hFFFF);
    test_width4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time bound so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
